seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, default 8, datapath width; legal range 4..32.
REQ-002 Port: Clk  input  1  rising-edge clock for all state.
REQ-003 Port: Reset  input  1  synchronous, active-high reset.
REQ-004 Port: Start  input  1  request to execute OP on InputA/InputB; sampled only while Busy=0.
REQ-005 Port: OP  input  4  opcode (see REQ-010).
REQ-006 Port: InputA  input  WIDTH  first operand.
REQ-007 Port: InputB  input  WIDTH  second operand, or shift amount.
REQ-008 Port: Out  output  WIDTH  registered result; holds its value between completions.
REQ-009 Port: OverflowOut  output  1  registered carry/borrow flag; this is also the carry-in for ADD/SUB. No external carry-in port.
REQ-010 Port: Busy  output  1  high while a multi-cycle op is in progress.
REQ-011 Port: Done  output  1  one-cycle pulse in the cycle Out/OverflowOut take the new result.

Function
REQ-012 Opcode map; C = OverflowOut; C is unchanged unless stated:
- 0 ADD: {C,Out} = A+B+C.
- 1 SUB: Out = (A-B-C) mod 2^WIDTH; C = 1 iff A < B+C, unsigned.
- 2 MOV: Out = B.
- 3 CPY: Out = A.
- 4 NAND; 5 OR.
- 6 SLL, 7 SRL, 8 SRA: shift A by unsigned B.
- 9 MUL: Out = low WIDTH bits of A*B, unsigned; C = 1 iff high half nonzero.
- 10 RST: C = 0; Out unchanged.
- 11 LT: Out = (A<B) unsigned, as 1 or 0.
- 12 EQ: Out = (A==B).
- 13 NOT: Out = ~B.
- 14 LTS: Out = (A<B), signed two's complement.
- 15 reserved: Out = 0.
REQ-013 On Start=1 with Busy=0, operands and OP are latched in that cycle; later changes on the inputs have no effect on the result.
REQ-014 Single-cycle ops (all except 6-9): Start accepted at edge t; Done=1 and the result is visible after edge t+1; Busy stays 0.
REQ-015 Shifts are iterative, one bit position per cycle; iteration count k = min(B, WIDTH).
- k=0: behaves as a single-cycle op; Out = A.
- Otherwise Busy=1 for k cycles and Done follows at edge t+1+k.
REQ-016 Shift results for B >= WIDTH: SLL/SRL give 0; SRA gives WIDTH copies of A's sign bit.
REQ-017 MUL is shift-add, one multiplier bit per cycle; Busy=1 for WIDTH cycles; Done at edge t+1+WIDTH, for any operand values, including 0.
REQ-018 FSM states: IDLE, ITER, FIN.
- IDLE -> ITER on a multi-cycle Start.
- ITER -> FIN when the iteration counter reaches its terminal count.
- FIN asserts Done and returns to IDLE.
- Single-cycle Start goes IDLE -> FIN.
REQ-019 Start while Busy=1 is ignored and does not queue.
REQ-020 A Start in the same cycle as a Done is accepted; back-to-back single-cycle ops therefore issue every 2 cycles.
REQ-021 Done asserts only for exactly one cycle per accepted Start.

Reset
REQ-022 Reset=1 forces at the next edge: state IDLE, Out=0, OverflowOut=0, Busy=0, Done=0, iteration counter=0.
REQ-023 Reset takes priority over Start.
REQ-024 Reset mid-operation aborts the op with no Done pulse; Out and OverflowOut are not updated with partial results.

Structure
REQ-025 Shared package seq_alu_pkg holds the opcode localparams, the FSM state enum, and the function is_multicycle(op).
REQ-026 One sub-module, seq_alu_iter, contains the iterative shift/multiply datapath and counter; it uses a start/done interface to the top FSM.

Verification
REQ-027 WIDTH=8, C=0: ADD A=0xFF B=0x01 -> Out=0x00, C=1, Done 1 cycle after Start; then ADD A=0 B=0 -> Out=0x01, C=0.
REQ-028 SUB A=0x05 B=0x07, C=0 -> Out=0xFE, C=1; then RST -> C=0 and Out remains 0xFE.
REQ-029 SRA A=0x80 B=3 -> Busy for 3 cycles, Out=0xF0; SRA A=0x80 B=200 -> Busy for 8 cycles, Out=0xFF; SLL B=0 -> single-cycle, Out=A.
REQ-030 MUL A=0x10 B=0x11 -> Done at t+9, Out=0x10, C=1; a Start pulsed during Busy -> ignored, exactly one Done.
REQ-031 LTS A=0x80 B=0x01 -> Out=1; LT with the same operands -> Out=0; EQ A=B=0x3C -> Out=1.
REQ-032 Reset asserted on cycle 4 of a MUL -> no Done; Out=0 and C=0 next cycle; a fresh ADD afterwards is correct. Repeat REQ-027 to REQ-031 with WIDTH=16.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared opcode map, FSM state encoding and opcode classification helpers
// for the sequential ALU.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MOV  = 4'd2;
    localparam logic [3:0] OP_CPY  = 4'd3;
    localparam logic [3:0] OP_NAND = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_RST  = 4'd10;
    localparam logic [3:0] OP_LT   = 4'd11;
    localparam logic [3:0] OP_EQ   = 4'd12;
    localparam logic [3:0] OP_NOT  = 4'd13;
    localparam logic [3:0] OP_LTS  = 4'd14;
    localparam logic [3:0] OP_RSVD = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op >= OP_SLL) && (op <= OP_MUL);
    endfunction

    function automatic logic is_shift(input logic [3:0] op);
        return (op >= OP_SLL) && (op <= OP_SRA);
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative datapath: one-bit-per-cycle shifter and shift-add multiplier,
// with the iteration counter that paces the top-level FSM.
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] result_o,
    output logic             hi_nz_o
);

    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(WIDTH);
    localparam logic [WIDTH:0]  W_EXT    = (WIDTH + 1)'(WIDTH);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] mcand_q, hi_q, lo_q;
    logic [WIDTH:0]   sum;
    logic             b_big;

    // Shift counts at or beyond WIDTH saturate: WIDTH single-bit steps already
    // empty the register (or fill it with the sign bit for SRA).
    assign b_big = ({1'b0, b_i} >= W_EXT);

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            if (op_i == OP_MUL || b_big) begin
                cnt_d = CNT_FULL;
            end else begin
                cnt_d = b_i[CW-1:0];
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);

    // Multiply keeps {hi,lo} as the running product with the multiplier
    // consumed from the bottom of lo, one bit per step.
    always_ff @(posedge Clk) begin
        if (start_i) begin
            op_q    <= op_i;
            mcand_q <= a_i;
            hi_q    <= '0;
            lo_q    <= (op_i == OP_MUL) ? b_i : a_i;
        end else if (cnt_q != '0) begin
            case (op_q)
                OP_SLL:  lo_q <= {lo_q[WIDTH-2:0], 1'b0};
                OP_SRL:  lo_q <= {1'b0, lo_q[WIDTH-1:1]};
                OP_SRA:  lo_q <= {lo_q[WIDTH-1], lo_q[WIDTH-1:1]};
                OP_MUL: begin
                    hi_q <= sum[WIDTH:1];
                    lo_q <= {sum[0], lo_q[WIDTH-1:1]};
                end
                default: ;
            endcase
        end
    end

    assign last_o   = (cnt_q == CW'(1));
    assign result_o = lo_q;
    assign hi_nz_o  = |hi_q;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU top: latches a request, runs single-cycle ops directly and
// hands shifts/multiply to the iterative datapath, then posts a Done pulse.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       OP,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    output logic [WIDTH-1:0] Out,
    output logic             OverflowOut,
    output logic             Busy,
    output logic             Done
);

    state_e                  state_q;
    logic [3:0]              op_q;
    logic [WIDTH-1:0]        a_q, b_q, out_q;
    logic                    c_q, busy_q, done_q;
    logic                    accept, go_iter, iter_last, iter_hi_nz;
    logic [WIDTH-1:0]        iter_res, res_d;
    logic                    c_d;
    logic signed [WIDTH-1:0] a_s, b_s;
    logic [WIDTH:0]          add_w, sub_w;

    assign accept  = (state_q == ST_IDLE) && Start;
    // A zero-distance shift has nothing to iterate and completes like a
    // single-cycle op.
    assign go_iter = accept && is_multicycle(OP) && !(is_shift(OP) && (InputB == '0));

    seq_alu_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .Clk      (Clk),
        .Reset    (Reset),
        .start_i  (go_iter),
        .op_i     (OP),
        .a_i      (InputA),
        .b_i      (InputB),
        .last_o   (iter_last),
        .result_o (iter_res),
        .hi_nz_o  (iter_hi_nz)
    );

    always_ff @(posedge Clk) begin
        if (accept) begin
            op_q <= OP;
            a_q  <= InputA;
            b_q  <= InputB;
        end
    end

    assign a_s   = a_q;
    assign b_s   = b_q;
    assign add_w = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, c_q};
    assign sub_w = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, c_q};

    always_comb begin
        res_d = out_q;
        c_d   = c_q;
        case (op_q)
            OP_ADD: begin
                res_d = add_w[WIDTH-1:0];
                c_d   = add_w[WIDTH];
            end
            OP_SUB: begin
                res_d = sub_w[WIDTH-1:0];
                c_d   = sub_w[WIDTH];
            end
            OP_MOV:  res_d = b_q;
            OP_CPY:  res_d = a_q;
            OP_NAND: res_d = ~(a_q & b_q);
            OP_OR:   res_d = a_q | b_q;
            OP_SLL, OP_SRL, OP_SRA: res_d = (b_q == '0) ? a_q : iter_res;
            OP_MUL: begin
                res_d = iter_res;
                c_d   = iter_hi_nz;
            end
            OP_RST:  c_d   = 1'b0;
            OP_LT:   res_d = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
            OP_EQ:   res_d = {{(WIDTH-1){1'b0}}, (a_q == b_q)};
            OP_NOT:  res_d = ~b_q;
            OP_LTS:  res_d = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        if (go_iter) begin
                            state_q <= ST_ITER;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_FIN;
                        end
                    end
                end
                ST_ITER: begin
                    if (iter_last) begin
                        state_q <= ST_FIN;
                        busy_q  <= 1'b0;
                    end
                end
                ST_FIN: begin
                    out_q   <= res_d;
                    c_q     <= c_d;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Out         = out_q;
    assign OverflowOut = c_q;
    assign Busy        = busy_q;
    assign Done        = done_q;

endmodule
